// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encoding and pipeline NOP for hazard control
package hazard_pkg;
   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERROR    = 2'd2
   } hazard_state_t;
   localparam logic [31:0] NOP_INSTR = 32'h00000013;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 32
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);
   always_ff @(posedge i_clk)
      o_count <= i_rst ? '0 : (i_inc && !(&o_count)) ? o_count + W'(1) : o_count;
endmodule

// File: rtl/hazard_detection_unit.sv
// hazard_detection_unit: load-use bubbles, data-memory freeze with timeout,
// and taken-branch flushes for the 5-stage pipeline.
module hazard_detection_unit
   import hazard_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [4:0]       i_rs1_IFID,
   input  logic [4:0]       i_rs2_IFID,
   input  logic             i_uses_rs1_IFID,
   input  logic             i_uses_rs2_IFID,
   input  logic [4:0]       i_rd_IDEX,
   input  logic             i_clu_MemRead_IDEX,
   input  logic             i_dmem_req_EXMEM,
   input  logic             i_dmem_ready,
   input  logic             i_branch_taken_EX,
   output logic             o_pc_write,
   output logic             o_ifid_write,
   output logic             o_idex_bubble,
   output logic             o_ifid_flush,
   output logic             o_idex_flush,
   output logic             o_pipe_hold,
   output logic             o_mem_timeout,
   output logic [CNT_W-1:0] o_stall_cycles,
   output logic [CNT_W-1:0] o_flush_count
);
   hazard_state_t state, state_n;
   logic [TO_W-1:0] cnt, cnt_n;
   logic lu, mw;
   assign lu = i_clu_MemRead_IDEX && i_rd_IDEX != 5'd0 &&
               ((i_uses_rs1_IFID && i_rs1_IFID == i_rd_IDEX) ||
                (i_uses_rs2_IFID && i_rs2_IFID == i_rd_IDEX));
   assign mw = i_dmem_req_EXMEM && !i_dmem_ready;
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end
   // Reset forces the RUN defaults regardless of the stored state.
   always_comb begin
      o_pc_write    = 1'b1;
      o_ifid_write  = 1'b1;
      o_idex_bubble = 1'b0;
      o_ifid_flush  = 1'b0;
      o_idex_flush  = 1'b0;
      o_pipe_hold   = 1'b0;
      o_mem_timeout = 1'b0;
      state_n       = state;
      cnt_n         = cnt;
      if (!i_rst) begin
         if (state == ERROR) begin
            o_pc_write    = 1'b0;
            o_ifid_write  = 1'b0;
            o_pipe_hold   = 1'b1;
            o_mem_timeout = 1'b1;
         end else if (mw) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_pipe_hold  = 1'b1;
            if (state == MEM_WAIT) begin
               state_n = (cnt >= TO_W'(MEM_TIMEOUT)) ? ERROR : MEM_WAIT;
               cnt_n   = (cnt >= TO_W'(MEM_TIMEOUT)) ? cnt : cnt + TO_W'(1);
            end else begin
               state_n = MEM_WAIT;
               cnt_n   = TO_W'(1);
            end
         end else begin
            state_n = RUN;
            cnt_n   = '0;
            if (i_branch_taken_EX) begin
               o_ifid_flush = 1'b1;
               o_idex_flush = 1'b1;
            end else if (lu) begin
               o_pc_write    = 1'b0;
               o_ifid_write  = 1'b0;
               o_idex_bubble = 1'b1;
            end
         end
      end
   end
   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (!o_pc_write),
      .o_count (o_stall_cycles)
   );
   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_inc   (o_ifid_flush),
      .o_count (o_flush_count)
   );
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb_hazard_detection_unit: directed vectors with hand-computed control words
// {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold, mem_timeout}.
module tb_hazard_detection_unit;
   localparam int CNT_W = 4;
   logic clk = 1'b0;
   logic rst;
   logic [4:0] rs1, rs2, rd;
   logic uses_rs1, uses_rs2, mem_read, dmem_req, dmem_ready, branch_taken;
   logic pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold, mem_timeout;
   logic [CNT_W-1:0] stall_cycles, flush_count;
   logic [6:0] ctl;
   int checks = 0;
   int errors = 0;
   localparam logic [6:0] C_RUN   = 7'b1100000;
   localparam logic [6:0] C_LU    = 7'b0010000;
   localparam logic [6:0] C_FLUSH = 7'b1101100;
   localparam logic [6:0] C_HOLD  = 7'b0000010;
   localparam logic [6:0] C_ERR   = 7'b0000011;
   always #5 clk = ~clk;
   assign ctl = {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, pipe_hold, mem_timeout};
   hazard_detection_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(4), .TO_W(16)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_rs1_IFID         (rs1),
      .i_rs2_IFID         (rs2),
      .i_uses_rs1_IFID    (uses_rs1),
      .i_uses_rs2_IFID    (uses_rs2),
      .i_rd_IDEX          (rd),
      .i_clu_MemRead_IDEX (mem_read),
      .i_dmem_req_EXMEM   (dmem_req),
      .i_dmem_ready       (dmem_ready),
      .i_branch_taken_EX  (branch_taken),
      .o_pc_write         (pc_write),
      .o_ifid_write       (ifid_write),
      .o_idex_bubble      (idex_bubble),
      .o_ifid_flush       (ifid_flush),
      .o_idex_flush       (idex_flush),
      .o_pipe_hold        (pipe_hold),
      .o_mem_timeout      (mem_timeout),
      .o_stall_cycles     (stall_cycles),
      .o_flush_count      (flush_count)
   );
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic clear;
      {rs1, rs2, rd} = '0;
      {uses_rs1, uses_rs2, mem_read, dmem_req, dmem_ready, branch_taken} = '0;
   endtask
   task automatic do_reset;
      clear();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
   endtask
   task automatic set_lu(input logic [4:0] r);
      mem_read = 1'b1;
      rd = r;
      rs1 = r;
      uses_rs1 = 1'b1;
   endtask
   initial begin
      clear();
      rst = 1'b1;
      tick();
      #1;
      chk("rst_ctl", 32'(ctl), 32'(C_RUN));
      chk("rst_stall", 32'(stall_cycles), 0);
      chk("rst_flush", 32'(flush_count), 0);
      rst = 1'b0;
      #1;
      set_lu(5'd5);
      #1;
      chk("lu_ctl", 32'(ctl), 32'(C_LU));
      tick();
      mem_read = 1'b0;
      #1;
      chk("lu_clear", 32'(ctl), 32'(C_RUN));
      chk("lu_stall", 32'(stall_cycles), 1);
      mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; uses_rs1 = 1'b1;
      #1;
      chk("x0_ctl", 32'(ctl), 32'(C_RUN));
      rd = 5'd7; rs1 = 5'd1; uses_rs1 = 1'b0; rs2 = 5'd7; uses_rs2 = 1'b0;
      #1;
      chk("unused_rs2", 32'(ctl), 32'(C_RUN));
      uses_rs2 = 1'b1;
      #1;
      chk("used_rs2", 32'(ctl), 32'(C_LU));
      do_reset();
      set_lu(5'd9);
      branch_taken = 1'b1;
      #1;
      chk("br_lu_ctl", 32'(ctl), 32'(C_FLUSH));
      tick();
      clear();
      #1;
      chk("br_flush_cnt", 32'(flush_count), 1);
      chk("br_stall_cnt", 32'(stall_cycles), 0);
      do_reset();
      dmem_req = 1'b1; branch_taken = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk($sformatf("mw_hold%0d", i), 32'(ctl), 32'(C_HOLD));
         tick();
      end
      dmem_ready = 1'b1;
      #1;
      chk("mw_release", 32'(ctl), 32'(C_FLUSH));
      tick();
      clear();
      #1;
      chk("mw_stall", 32'(stall_cycles), 3);
      chk("mw_flush", 32'(flush_count), 1);
      chk("mw_run", 32'(ctl), 32'(C_RUN));
      do_reset();
      dmem_req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk($sformatf("to_hold%0d", i), 32'(ctl), 32'(C_HOLD));
         tick();
      end
      #1;
      chk("to_err", 32'(ctl), 32'(C_ERR));
      dmem_ready = 1'b1; dmem_req = 1'b0;
      tick();
      chk("to_sticky", 32'(ctl), 32'(C_ERR));
      chk("to_stall", 32'(stall_cycles), 6);
      rst = 1'b1;
      #1;
      chk("to_rst_ctl", 32'(ctl), 32'(C_RUN));
      tick();
      rst = 1'b0;
      #1;
      chk("to_run", 32'(ctl), 32'(C_RUN));
      chk("to_stall0", 32'(stall_cycles), 0);
      chk("to_flush0", 32'(flush_count), 0);
      do_reset();
      set_lu(5'd3);
      for (int i = 0; i < 20; i++) begin
         if (i == 14) chk("sat_14", 32'(stall_cycles), 14);
         tick();
      end
      chk("sat_ctl", 32'(ctl), 32'(C_LU));
      chk("sat_15", 32'(stall_cycles), 15);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
